// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encoding, index sizing.
package nsa_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Nibble index width for a given operand width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned width);
    int unsigned nib;
    nib = width / NIBBLE_W;
    return (nib <= 1) ? 32'd1 : 32'($clog2(nib));
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit adder slice; also exposes the carry into bit 3 for signed-overflow use.
module nibble_add4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       ci,
  output logic [3:0] s4,
  output logic       co,
  output logic       c3
);

  logic [3:0] low;
  logic [1:0] top;

  always_comb begin
    low = {1'b0, a4[2:0]} + {1'b0, b4[2:0]} + {3'b000, ci};
    top = {1'b0, a4[3]} + {1'b0, b4[3]} + {1'b0, low[3]};
    s4  = {top[0], low[2:0]};
    co  = top[1];
    c3  = low[3];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder processing one nibble per clock through a single 4-bit slice.
// Optional signed-overflow output enabled with macro NSA_SIGNED_OVF_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef NSA_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = idx_width(WIDTH);

  generate
    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         slice_s;
  logic               slice_co;
  logic               last_c;
  logic               accept_c;
`ifdef NSA_SIGNED_OVF_EN
  logic               slice_c3;
`else
  logic               slice_c3_unused;
`endif

  assign last_c   = (idx_q == IDX_W'(NIB - 1));
  assign accept_c = (state_q == IDLE) && in_valid;

  nibble_add4 u_slice (
    .a4 (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b4 (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .ci (carry_q),
    .s4 (slice_s),
    .co (slice_co),
`ifdef NSA_SIGNED_OVF_EN
    .c3 (slice_c3)
`else
    .c3 (slice_c3_unused)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_c)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake/status flags track the upcoming state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d == RUN) || (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef NSA_SIGNED_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept_c) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx_q   <= '0;
      sum     <= '0;
    end else if (state_q == RUN) begin
      sum[idx_q*NIBBLE_W +: NIBBLE_W] <= slice_s;
      carry_q <= slice_co;
      idx_q   <= idx_q + IDX_W'(1);
      if (last_c) begin
        cout <= slice_co;
`ifdef NSA_SIGNED_OVF_EN
        ovf  <= slice_co ^ slice_c3;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: a 16-bit and a 4-bit instance checked against plain-arithmetic expectations.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, co16, busy16, ci16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0, co4, busy4, ci4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, s4;
`ifdef NSA_SIGNED_OVF_EN
  logic        ovf16, ovf4;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16),
`ifdef NSA_SIGNED_OVF_EN
    .ovf(ovf16),
`endif
    .busy(busy16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4),
`ifdef NSA_SIGNED_OVF_EN
    .ovf(ovf4),
`endif
    .busy(busy4)
  );

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance, with bp extra cycles of backpressure in DONE.
  task automatic op(input bit n4, input logic [15:0] ta, input logic [15:0] tb,
                    input logic tc, input int bp);
    int          w, lat;
    logic [15:0] mask, am, bm, exp_sum;
    logic [16:0] full;
    logic        exp_co, exp_ovf;
    w       = n4 ? 4 : 16;
    mask    = n4 ? 16'h000F : 16'hFFFF;
    am      = ta & mask;
    bm      = tb & mask;
    full    = {1'b0, am} + {1'b0, bm} + {16'd0, tc};
    exp_sum = full[15:0] & mask;
    exp_co  = n4 ? full[4] : full[16];
    exp_ovf = (am[w-1] == bm[w-1]) && (exp_sum[w-1] != am[w-1]);

    @(negedge clk);
    check(32'(n4 ? ir4 : ir16), 32'd1, "in_ready_idle");
    if (n4) begin a4 = am[3:0]; b4 = bm[3:0]; ci4 = tc; iv4 = 1'b1; end
    else    begin a16 = am;     b16 = bm;     ci16 = tc; iv16 = 1'b1; end
    @(negedge clk);
    iv4 = 1'b0; iv16 = 1'b0;
    lat = 1;
    while (!(n4 ? ov4 : ov16) && lat < 40) begin
      a16 = 16'($urandom); b16 = 16'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    check(32'(lat), 32'(w / 4 + 1), "latency");
    check(32'(n4 ? {12'd0, s4} : s16), 32'(exp_sum), "sum");
    check(32'(n4 ? co4 : co16), 32'(exp_co), "cout");
`ifdef NSA_SIGNED_OVF_EN
    check(32'(n4 ? ovf4 : ovf16), 32'(exp_ovf), "ovf");
`endif
    check(32'(n4 ? ir4 : ir16), 32'd0, "in_ready_done");
    check(32'(n4 ? busy4 : busy16), 32'd1, "busy_done");

    for (int i = 0; i < bp; i++) begin
      if (n4) begin iv4 = 1'b1; a4 = 4'h1; end
      else    begin iv16 = 1'b1; a16 = 16'h0001; end
      @(negedge clk);
      check(32'(n4 ? {12'd0, s4} : s16), 32'(exp_sum), "bp_sum");
      check(32'(n4 ? co4 : co16), 32'(exp_co), "bp_cout");
      check(32'(n4 ? ov4 : ov16), 32'd1, "bp_valid");
      check(32'(n4 ? ir4 : ir16), 32'd0, "bp_in_ready");
    end

    iv4 = 1'b0; iv16 = 1'b0;
    if (n4) or4 = 1'b1; else or16 = 1'b1;
    @(negedge clk);
    or4 = 1'b0; or16 = 1'b0;
    check(32'(n4 ? ov4 : ov16), 32'd0, "valid_after_hs");
    check(32'(n4 ? ir4 : ir16), 32'd1, "in_ready_after_hs");
    check(32'(n4 ? busy4 : busy16), 32'd0, "busy_after_hs");
  endtask

  initial begin
    int seen;
    // Reset state
    #12;
    check(32'(ir16), 32'd1, "rst_in_ready");
    check(32'(ov16), 32'd0, "rst_out_valid");
    check(32'(busy16), 32'd0, "rst_busy");
    check(32'(s16), 32'd0, "rst_sum");
    check(32'(co16), 32'd0, "rst_cout");
    rst_n = 1'b1;

    // Directed cases
    op(1'b0, 16'h1234, 16'h4321, 1'b1, 0);
    op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 0);
    op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 0);
    op(1'b0, 16'h8000, 16'h8000, 1'b1, 0);
    op(1'b0, 16'hABCD, 16'h0000, 1'b0, 10);
    op(1'b1, 16'h000F, 16'h000F, 1'b1, 0);
    op(1'b1, 16'h0007, 16'h0001, 1'b0, 2);

    // Reset during the second RUN cycle
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0; iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(32'(ov16), 32'd0, "midrst_out_valid");
    check(32'(ir16), 32'd1, "midrst_in_ready");
    check(32'(busy16), 32'd0, "midrst_busy");
    check(32'(s16), 32'd0, "midrst_sum");
    check(32'(co16), 32'd0, "midrst_cout");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov16) seen++;
    end
    check(32'(seen), 32'd0, "no_valid_after_rst");
    op(1'b0, 16'h0002, 16'h0003, 1'b0, 0);

    // Randomized transactions on both widths
    for (int i = 0; i < 12; i++)
      op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    for (int i = 0; i < 8; i++)
      op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
